// File: rtl/clk_pkg.sv
// Shared constants, FSM state type and phase-length helpers for the clock divider.
package clk_pkg;

    // Ratios at or below this value select the bypass path.
    localparam int unsigned RATIO_BYPASS_MAX = 1;

    typedef enum logic [1:0] {
        BYPASS,
        HIGH,
        LOW
    } div_state_t;

    // High phase length in reference cycles for ratio n.
    function automatic int unsigned hi_len(input int unsigned n);
        return n >> 1;
    endfunction

    // Low phase length; takes the extra cycle for odd ratios.
    function automatic int unsigned lo_len(input int unsigned n);
        return n - (n >> 1);
    endfunction

endpackage

// File: rtl/clk_bypass_mux.sv
// 2:1 clock mux kept as its own module so it can map to a library clock-mux cell.
module clk_bypass_mux (
    input  logic sel,
    input  logic clk_ref,
    input  logic clk_div,
    output logic clk_out
);

    assign clk_out = sel ? clk_ref : clk_div;

endmodule

// File: rtl/int_clk_div.sv
// Programmable integer clock divider with glitch-free bypass.
// Configuration is reloaded every edge while bypassed, and only at the end of a
// high phase while dividing, so the output never carries a runt pulse.
module int_clk_div
    import clk_pkg::*;
#(
    parameter int unsigned RATIO_WD = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CLK_EN,
    input  logic [RATIO_WD-1:0] DIV_RATIO,
    output logic                DIV_CLK
);

    div_state_t          state;
    div_state_t          state_n;
    logic [RATIO_WD-1:0] cnt;
    logic [RATIO_WD-1:0] cnt_n;
    logic                div_q;
    logic                div_q_n;
    logic                act_bypass;
    logic                act_bypass_n;
    logic [RATIO_WD-1:0] act_ratio;
    logic [RATIO_WD-1:0] act_ratio_n;

    logic                cfg_bypass;
    logic [RATIO_WD-1:0] hi_last;
    logic [RATIO_WD-1:0] lo_last;

    assign cfg_bypass = !CLK_EN || (32'(DIV_RATIO) <= RATIO_BYPASS_MAX);
    assign hi_last    = RATIO_WD'(hi_len(32'(act_ratio)) - 1);
    assign lo_last    = RATIO_WD'(lo_len(32'(act_ratio)) - 1);

    // State, phase counter, divided clock and active configuration registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= BYPASS;
            cnt        <= '0;
            div_q      <= 1'b0;
            act_bypass <= 1'b1;
            act_ratio  <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            div_q      <= div_q_n;
            act_bypass <= act_bypass_n;
            act_ratio  <= act_ratio_n;
        end
    end

    // Phase sequencing; the end of a high phase is the only reload point while dividing.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        div_q_n      = div_q;
        act_bypass_n = act_bypass;
        act_ratio_n  = act_ratio;
        case (state)
            BYPASS: begin
                act_ratio_n  = DIV_RATIO;
                act_bypass_n = cfg_bypass;
                cnt_n        = '0;
                if (cfg_bypass) begin
                    div_q_n = 1'b0;
                end else begin
                    // CLK is high just after this edge, so starting high avoids a runt.
                    div_q_n = 1'b1;
                    state_n = HIGH;
                end
            end
            HIGH: begin
                if (cnt == hi_last) begin
                    act_ratio_n  = DIV_RATIO;
                    act_bypass_n = cfg_bypass;
                    div_q_n      = 1'b0;
                    cnt_n        = '0;
                    state_n      = cfg_bypass ? BYPASS : LOW;
                end else begin
                    cnt_n = cnt + RATIO_WD'(1);
                end
            end
            LOW: begin
                if (cnt == lo_last) begin
                    div_q_n = 1'b1;
                    cnt_n   = '0;
                    state_n = HIGH;
                end else begin
                    cnt_n = cnt + RATIO_WD'(1);
                end
            end
            default: begin
                state_n      = BYPASS;
                cnt_n        = '0;
                div_q_n      = 1'b0;
                act_bypass_n = 1'b1;
            end
        endcase
    end

    clk_bypass_mux u_mux (
        .sel     (act_bypass),
        .clk_ref (CLK),
        .clk_div (div_q),
        .clk_out (DIV_CLK)
    );

endmodule

// File: tb/tb_int_clk_div.sv
// Randomized self-checking bench for int_clk_div against a waveform-queue model.
module tb_int_clk_div;

    localparam int unsigned RATIO_WD = 8;

    logic                CLK;
    logic                RST;
    logic                CLK_EN;
    logic [RATIO_WD-1:0] DIV_RATIO;
    logic                DIV_CLK;

    int checks = 0;
    int errors = 0;
    string section = "init";

    // Model: bypass flag plus a queue of output levels still to be emitted in
    // divide mode (one entry per reference cycle).
    bit m_byp;
    bit m_level;
    bit m_prev;
    bit q[$];

    int_clk_div #(.RATIO_WD(RATIO_WD)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CLK_EN    (CLK_EN),
        .DIV_RATIO (DIV_RATIO),
        .DIV_CLK   (DIV_CLK)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s/%s @%0t: got %b expected %b", section, tag, $time, obs, exp);
        end
    endtask

    task automatic push_levels(input bit lvl, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) q.push_back(lvl);
    endtask

    // Advance the model by one reference rising edge using the current inputs.
    task automatic model_edge();
        bit cfg;
        int unsigned n;
        m_prev = m_byp ? 1'b0 : m_level;
        if (!RST) begin
            m_byp = 1'b1;
            q.delete();
            return;
        end
        n   = 32'(DIV_RATIO);
        cfg = !CLK_EN || (n < 2);
        if (m_byp) begin
            if (!cfg) begin
                m_byp = 1'b0;
                push_levels(1'b1, n / 2);
                m_level = q.pop_front();
            end
        end else if (q.size() == 0) begin
            // High phase just ended: this edge is the reload point.
            if (cfg) begin
                m_byp = 1'b1;
            end else begin
                push_levels(1'b0, n - n / 2);
                push_levels(1'b1, n / 2);
                m_level = q.pop_front();
            end
        end else begin
            m_level = q.pop_front();
        end
    endtask

    // One reference cycle: check the high half and the low half of CLK.
    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        chk("clk_hi_half", DIV_CLK, m_byp ? 1'b1 : m_level);
        @(negedge CLK);
        #1;
        chk("clk_lo_half", DIV_CLK, m_byp ? 1'b0 : m_level);
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset assertion in the low half of CLK.
    task automatic assert_rst();
        RST = 1'b0;
        m_byp = 1'b1;
        q.delete();
        #1;
        chk("rst_async", DIV_CLK, 1'b0);
    endtask

    // Step until the model enters the requested level in divide mode.
    task automatic wait_level(input bit lvl, input bit edge_only);
        bit found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            step();
            if (!m_byp && m_level == lvl && (!edge_only || m_prev != lvl)) found = 1'b1;
        end
        chk("sync_timeout", found, 1'b1);
    endtask

    initial begin
        RST       = 1'b0;
        CLK_EN    = 1'b1;
        DIV_RATIO = 8'd4;
        m_byp     = 1'b1;
        m_level   = 1'b0;
        m_prev    = 1'b0;

        section = "reset";
        @(negedge CLK);
        #1;
        chk("rst_state", DIV_CLK, 1'b0);
        run(4);
        RST = 1'b1;
        section = "n4";
        run(16);

        section = "n5";
        DIV_RATIO = 8'd5;
        run(105);

        section = "n8_to_n2";
        DIV_RATIO = 8'd8;
        run(20);
        wait_level(1'b1, 1'b1);
        step();
        DIV_RATIO = 8'd2;
        run(30);

        section = "bypass_entry_exit";
        DIV_RATIO = 8'd6;
        run(20);
        wait_level(1'b0, 1'b1);
        CLK_EN = 1'b0;
        run(20);
        CLK_EN = 1'b1;
        run(30);

        section = "bypass_ratios";
        DIV_RATIO = 8'd0;
        run(12);
        DIV_RATIO = 8'd1;
        run(12);
        section = "n255";
        DIV_RATIO = 8'd255;
        run(600);

        section = "reset_mid_low";
        DIV_RATIO = 8'd10;
        run(30);
        wait_level(1'b0, 1'b1);
        run(2);
        assert_rst();
        run(3);
        RST = 1'b1;
        run(30);

        section = "random";
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) < 8) DIV_RATIO = RATIO_WD'($urandom_range(0, 12));
            else DIV_RATIO = RATIO_WD'($urandom_range(13, 40));
            CLK_EN = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 15) == 0) begin
                assert_rst();
                run(2);
                RST = 1'b1;
            end
            run($urandom_range(1, 40));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
